// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, code field positions, FSM states.
package alu_pkg;

    localparam int CODE_W  = 18;
    localparam int OPA_MSB = 17;
    localparam int OPA_LSB = 10;
    localparam int OPB_MSB = 9;
    localparam int OPB_LSB = 2;
    localparam int OPC_MSB = 1;
    localparam int OPC_LSB = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    function automatic logic [1:0] code_opcode(input logic [CODE_W-1:0] code);
        return code[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; grant is combinational from the valids and the pointer.
// Pointer moves to the requester that was not granted whenever advance is strobed.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant
);

    logic ptr;

    // A lone requester wins outright; the pointer only breaks ties.
    assign grant = (valid0 && valid1) ? ptr : valid1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~grant;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Arbitrates two requesters and issues one operation at a time to the multi-cycle ALU.
// Latency: accept at T, response valid at T+2+LAT (LAT chosen by opcode).
// Backpressure: response held until resp_ready; no request accepted until it drains.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 10,
    parameter int LAT_DIV    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [CODE_W-1:0] req0_code,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [CODE_W-1:0] req1_code,
    output logic              req1_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [15:0]       resp_rez,
    output logic              resp_zero,
    output logic              resp_ovf,
    output logic              alu_rst,
    output logic [CODE_W-1:0] alu_code,
    input  logic [15:0]       alu_rez,
    input  logic              alu_flag_zero,
    input  logic              alu_flag_overflow
);

    if (LAT_ADDSUB < 1 || LAT_ADDSUB > 15) begin : g_bad_lat_addsub
        $error("alu_sequencer: LAT_ADDSUB must be within 1..15");
    end
    if (LAT_MUL < 1 || LAT_MUL > 15) begin : g_bad_lat_mul
        $error("alu_sequencer: LAT_MUL must be within 1..15");
    end
    if (LAT_DIV < 1 || LAT_DIV > 15) begin : g_bad_lat_div
        $error("alu_sequencer: LAT_DIV must be within 1..15");
    end

    function automatic logic [3:0] lat_of(input logic [1:0] op);
        case (op)
            OP_MUL:  return 4'(LAT_MUL);
            OP_DIV:  return 4'(LAT_DIV);
            default: return 4'(LAT_ADDSUB);
        endcase
    endfunction

    seq_state_t        state;
    logic [3:0]        cnt;
    logic              id_q;
    logic              grant;
    logic              accept;
    logic [CODE_W-1:0] code_sel;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign accept     = (state == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state == ST_IDLE) && req0_valid && !grant;
    assign req1_ready = (state == ST_IDLE) && req1_valid && grant;
    assign code_sel   = grant ? req1_code : req0_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            id_q       <= 1'b0;
            alu_rst    <= 1'b1;
            alu_code   <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_rez   <= 16'h0000;
            resp_zero  <= 1'b0;
            resp_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    alu_rst <= 1'b0;
                    if (accept) begin
                        alu_code <= code_sel;
                        id_q     <= grant;
                        cnt      <= lat_of(code_opcode(code_sel));
                        alu_rst  <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    alu_rst <= 1'b0;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    cnt <= cnt - 4'd1;
                    // The last RUN cycle is the one where the ALU result is final.
                    if (cnt == 4'd1) begin
                        resp_rez   <= alu_rez;
                        resp_zero  <= alu_flag_zero;
                        resp_ovf   <= alu_flag_overflow;
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural multi-cycle ALU that
// shows a garbage result until its latency has elapsed since alu_rst.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [17:0] req0_code, req1_code;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_ready, resp_id;
    logic [15:0] resp_rez;
    logic        resp_zero, resp_ovf;
    logic        alu_rst;
    logic [17:0] alu_code;
    logic [15:0] alu_rez;
    logic        alu_flag_zero, alu_flag_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .req0_valid        (req0_valid),
        .req0_code         (req0_code),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_code         (req1_code),
        .req1_ready        (req1_ready),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_id           (resp_id),
        .resp_rez          (resp_rez),
        .resp_zero         (resp_zero),
        .resp_ovf          (resp_ovf),
        .alu_rst           (alu_rst),
        .alu_code          (alu_code),
        .alu_rez           (alu_rez),
        .alu_flag_zero     (alu_flag_zero),
        .alu_flag_overflow (alu_flag_overflow)
    );

    // Behavioural ALU: cycles counted since alu_rst, result valid after LAT-1 of them.
    logic [4:0]  alu_cyc;
    logic [7:0]  op_a, op_b;
    logic [15:0] calc;
    logic        calc_ovf;
    logic [4:0]  need;

    always @(posedge clk) begin
        if (alu_rst) alu_cyc <= 5'd0;
        else if (alu_cyc != 5'd31) alu_cyc <= alu_cyc + 5'd1;
    end

    always_comb begin
        op_a     = alu_code[17:10];
        op_b     = alu_code[9:2];
        calc     = 16'h0000;
        calc_ovf = 1'b0;
        need     = alu_code[1] ? 5'd9 : 5'd1;
        case (alu_code[1:0])
            2'b00: begin
                calc     = {8'h00, op_a + op_b};
                calc_ovf = (op_a[7] == op_b[7]) && (calc[7] != op_a[7]);
            end
            2'b01: begin
                calc     = {8'h00, op_a - op_b};
                calc_ovf = (op_a[7] != op_b[7]) && (calc[7] != op_a[7]);
            end
            2'b10: calc = op_a * op_b;
            default: calc = (op_b != 0) ? {op_a % op_b, op_a / op_b} : 16'hFFFF;
        endcase
        if (alu_cyc >= need) begin
            alu_rez           = calc;
            alu_flag_zero     = (calc == 16'h0000);
            alu_flag_overflow = calc_ovf;
        end else begin
            alu_rez           = 16'hBAD0;
            alu_flag_zero     = 1'b1;
            alu_flag_overflow = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Issue one code from one requester and check the response; returns at the
    // negedge of the first RESP cycle (handshake completes at the next edge).
    task automatic run_op(input string tag, input logic id, input logic [17:0] code,
                          input int exp_cyc, input logic [15:0] exp_rez,
                          input logic exp_zero, input logic exp_ovf);
        int  k;
        int  rst_hi;
        logic got;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_code = code; end
        else    begin req0_valid = 1'b1; req0_code = code; end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        if (!got) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k      = 1;
        rst_hi = 0;
        while (!resp_valid && k < 40) begin
            if (alu_rst) rst_hi++;
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"},   32'(k),         32'(exp_cyc));
        chk({tag, "_rez"},   32'(resp_rez),  32'(exp_rez));
        chk({tag, "_id"},    32'(resp_id),   32'(id));
        chk({tag, "_zero"},  32'(resp_zero), 32'(exp_zero));
        chk({tag, "_ovf"},   32'(resp_ovf),  32'(exp_ovf));
        chk({tag, "_rsthi"}, 32'(rst_hi),    32'd1);
    endtask

    localparam logic [17:0] ADD_10_5 = 18'b00001010_00000101_00;
    localparam logic [17:0] SUB_10_5 = 18'b00001010_00000101_01;
    localparam logic [17:0] MUL_10_5 = 18'b00001010_00000101_10;
    localparam logic [17:0] DIV_10_5 = 18'b00001010_00000101_11;
    localparam logic [17:0] ADD_1_1  = 18'b00000001_00000001_00;
    localparam logic [17:0] ADD_2_2  = 18'b00000010_00000010_00;
    localparam logic [17:0] ADD_3_4  = 18'b00000011_00000100_00;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int   nresp;
        int   ngrant;
        int   seen;
        logic g_id [4];
        logic r_id [4];
        logic [15:0] r_rez [4];
        logic [15:0] exp_rez_tab [4];
        logic        last_g;

        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_code  = '0;
        req1_code  = '0;
        resp_ready = 1'b1;
        exp_rez_tab[0] = 16'h0002; exp_rez_tab[1] = 16'h0004;
        exp_rez_tab[2] = 16'h0002; exp_rez_tab[3] = 16'h0004;

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rez",   32'(resp_rez),   32'd0);
        chk("rst_resp_id",    32'(resp_id),    32'd0);
        chk("rst_alu_rst",    32'(alu_rst),    32'd1);
        chk("rst_alu_code",   32'(alu_code),   32'd0);
        rst = 1'b0;

        run_op("add",  1'b0, ADD_10_5, 4,  16'h000F, 1'b0, 1'b0);
        run_op("sub",  1'b1, SUB_10_5, 4,  16'h0005, 1'b0, 1'b0);
        run_op("mul",  1'b1, MUL_10_5, 12, 16'h0032, 1'b0, 1'b0);
        run_op("div",  1'b1, DIV_10_5, 12, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_holds_code", 32'(alu_code), 32'(DIV_10_5));

        // Backpressure: req0 add 3+4 held 20 cycles, req1 waiting meanwhile.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_code = ADD_3_4;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (req0_ready) seen = 1;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_code = ADD_2_2;
        seen = 0;
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        chk("bp_valid", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (resp_valid !== 1'b1 || resp_rez !== 16'h0007 || resp_id !== 1'b0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) seen++;
            @(negedge clk);
        end
        chk("bp_stable", 32'(seen), 32'd0);
        chk("bp_rez", 32'(resp_rez), 32'h0007);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", 32'(resp_valid), 32'd0);
        chk("bp_next_ready", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        chk("bp_next_rez", 32'(resp_rez), 32'h0004);
        chk("bp_next_id",  32'(resp_id),  32'd1);
        @(negedge clk);

        // Contention: both continuously valid, grants and responses alternate.
        req0_valid = 1'b1; req0_code = ADD_1_1;
        req1_valid = 1'b1; req1_code = ADD_2_2;
        nresp  = 0;
        ngrant = 0;
        seen   = 0;
        for (int i = 0; i < 200 && nresp < 4; i++) begin
            #1;
            if (req0_ready && req1_ready) seen++;
            if (ngrant < 4 && req0_ready) begin g_id[ngrant] = 1'b0; ngrant++; end
            else if (ngrant < 4 && req1_ready) begin g_id[ngrant] = 1'b1; ngrant++; end
            if (resp_valid) begin
                r_id[nresp]  = resp_id;
                r_rez[nresp] = resp_rez;
                nresp++;
            end
            if (nresp < 4) @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cont_nresp", 32'(nresp), 32'd4);
        chk("cont_both_ready", 32'(seen), 32'd0);
        last_g = 1'b1;
        for (int i = 0; i < nresp; i++) begin
            chk($sformatf("cont_grant%0d", i), 32'(g_id[i]), 32'(i % 2));
            chk($sformatf("cont_id%0d", i),    32'(r_id[i]), 32'(i % 2));
            chk($sformatf("cont_rez%0d", i),   32'(r_rez[i]), 32'(exp_rez_tab[i]));
            if (i > 0) chk($sformatf("cont_alt%0d", i), 32'(g_id[i] != last_g), 32'd1);
            last_g = g_id[i];
        end
        @(negedge clk);

        // Reset mid-multiply from req0 (pointer moves to 1 on that accept).
        req0_valid = 1'b1; req0_code = MUL_10_5;
        #1;
        chk("rm_accept", 32'(req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rm_valid",    32'(resp_valid), 32'd0);
        chk("rm_alu_rst",  32'(alu_rst),    32'd1);
        chk("rm_alu_code", 32'(alu_code),   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rm_no_resp", 32'(seen), 32'd0);

        // Pointer back at 0: with both valid req0 is granted (withdrawn before the edge).
        req0_valid = 1'b1; req0_code = ADD_1_1;
        req1_valid = 1'b1; req1_code = MUL_10_5;
        #1;
        chk("rm_ptr_r0", 32'(req0_ready), 32'd1);
        chk("rm_ptr_r1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        run_op("post_rst", 1'b1, MUL_10_5, 12, 16'h0032, 1'b0, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
